// File: rtl/reg_wb.sv
// reg_wb: write-back end of the cpu15 register file.
// Holds REG_0..REG_7, accepts one result write per CLK_WB edge and keeps a
// per-register outstanding-write counter so fetch/decode can stall on RAW hazards.
module reg_wb #(
    parameter int unsigned           DATA_W    = 16,
    parameter int unsigned           CNT_W     = 2,
    parameter logic [DATA_W-1:0]     RESET_VAL = '0
) (
    input  logic              CLK_WB,
    input  logic              N_RESET,
    input  logic              ISSUE_EN,
    input  logic [2:0]        N_ISSUE_REG,
    input  logic              WB_EN,
    input  logic [2:0]        N_REG_IN,
    input  logic [DATA_W-1:0] REG_IN,
    output logic [DATA_W-1:0] REG_0,
    output logic [DATA_W-1:0] REG_1,
    output logic [DATA_W-1:0] REG_2,
    output logic [DATA_W-1:0] REG_3,
    output logic [DATA_W-1:0] REG_4,
    output logic [DATA_W-1:0] REG_5,
    output logic [DATA_W-1:0] REG_6,
    output logic [DATA_W-1:0] REG_7,
    output logic [7:0]        PENDING,
    output logic              OVF,
    output logic              UNF
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs    [8];
    logic [CNT_W-1:0]  cnt     [8];
    logic [CNT_W-1:0]  cnt_nxt [8];
    logic [7:0]        pend_nxt;
    logic              ovf_set;
    logic              unf_set;

    // Next counter values and flag events for every register in parallel
    always_comb begin
        pend_nxt = '0;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        for (int unsigned n = 0; n < 8; n++) begin
            logic inc;
            logic dec;
            inc        = ISSUE_EN && (N_ISSUE_REG == 3'(n));
            dec        = WB_EN && (N_REG_IN == 3'(n));
            cnt_nxt[n] = cnt[n];
            if (inc && !dec) begin
                if (cnt[n] == CNT_MAX) ovf_set = 1'b1;
                else                   cnt_nxt[n] = cnt[n] + 1'b1;
            end else if (dec && !inc) begin
                if (cnt[n] == '0) unf_set = 1'b1;
                else              cnt_nxt[n] = cnt[n] - 1'b1;
            end
            pend_nxt[n] = (cnt_nxt[n] != '0);
        end
    end

    // Register data write-back
    always_ff @(posedge CLK_WB or negedge N_RESET) begin
        if (!N_RESET) begin
            for (int unsigned n = 0; n < 8; n++) regs[n] <= RESET_VAL;
        end else if (WB_EN) begin
            regs[N_REG_IN] <= REG_IN;
        end
    end

    // Scoreboard counters, PENDING and sticky error flags
    always_ff @(posedge CLK_WB or negedge N_RESET) begin
        if (!N_RESET) begin
            for (int unsigned n = 0; n < 8; n++) cnt[n] <= '0;
            PENDING <= '0;
            OVF     <= 1'b0;
            UNF     <= 1'b0;
        end else begin
            for (int unsigned n = 0; n < 8; n++) cnt[n] <= cnt_nxt[n];
            PENDING <= pend_nxt;
            if (ovf_set) OVF <= 1'b1;
            if (unf_set) UNF <= 1'b1;
        end
    end

    assign REG_0 = regs[0];
    assign REG_1 = regs[1];
    assign REG_2 = regs[2];
    assign REG_3 = regs[3];
    assign REG_4 = regs[4];
    assign REG_5 = regs[5];
    assign REG_6 = regs[6];
    assign REG_7 = regs[7];

endmodule

// File: tb/tb_reg_wb.sv
// Self-checking bench for reg_wb: stimulus pushes expected state per edge,
// a monitor pops and compares after each edge; directed vectors add hand checks.
module tb_reg_wb;

    logic        CLK_WB = 1'b0;
    logic        N_RESET = 1'b0;
    logic        ISSUE_EN = 1'b0;
    logic [2:0]  N_ISSUE_REG = '0;
    logic        WB_EN = 1'b0;
    logic [2:0]  N_REG_IN = '0;
    logic [15:0] REG_IN = '0;
    logic [15:0] REG_0, REG_1, REG_2, REG_3, REG_4, REG_5, REG_6, REG_7;
    logic [7:0]  PENDING;
    logic        OVF, UNF;

    reg_wb #(.DATA_W(16), .CNT_W(2), .RESET_VAL(16'h0000)) dut (
        .CLK_WB(CLK_WB), .N_RESET(N_RESET),
        .ISSUE_EN(ISSUE_EN), .N_ISSUE_REG(N_ISSUE_REG),
        .WB_EN(WB_EN), .N_REG_IN(N_REG_IN), .REG_IN(REG_IN),
        .REG_0(REG_0), .REG_1(REG_1), .REG_2(REG_2), .REG_3(REG_3),
        .REG_4(REG_4), .REG_5(REG_5), .REG_6(REG_6), .REG_7(REG_7),
        .PENDING(PENDING), .OVF(OVF), .UNF(UNF)
    );

    always #5 CLK_WB = ~CLK_WB;

    typedef struct packed {
        logic [7:0][15:0] regs;
        logic [7:0]       pend;
        logic             ovf;
        logic             unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    // reference model state
    logic [15:0] mreg [8];
    int          mcnt [8];
    logic        movf, munf;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_reg(input int n);
        case (n)
            0: return REG_0;
            1: return REG_1;
            2: return REG_2;
            3: return REG_3;
            4: return REG_4;
            5: return REG_5;
            6: return REG_6;
            default: return REG_7;
        endcase
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        for (int n = 0; n < 8; n++) begin
            e.regs[n] = mreg[n];
            e.pend[n] = (mcnt[n] != 0);
        end
        e.ovf = movf;
        e.unf = munf;
        return e;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < 8; n++) begin
            mreg[n] = 16'h0000;
            mcnt[n] = 0;
        end
        movf = 1'b0;
        munf = 1'b0;
    endtask

    task automatic check_all(input string tag, input exp_t e);
        for (int n = 0; n < 8; n++)
            chk($sformatf("%s REG_%0d", tag, n), {16'h0, dut_reg(n)}, {16'h0, e.regs[n]});
        chk({tag, " PENDING"}, {24'h0, PENDING}, {24'h0, e.pend});
        chk({tag, " OVF"}, {31'h0, OVF}, {31'h0, e.ovf});
        chk({tag, " UNF"}, {31'h0, UNF}, {31'h0, e.unf});
    endtask

    // monitor: one expected state per active edge
    always @(posedge CLK_WB) begin
        #1;
        if (exp_q.size() > 0) check_all("edge", exp_q.pop_front());
    end

    // drive one cycle of traffic, advance the model and queue its expectation
    task automatic step(input logic ie, input logic [2:0] ir,
                        input logic we, input logic [2:0] wr, input logic [15:0] wd);
        @(negedge CLK_WB);
        ISSUE_EN = ie; N_ISSUE_REG = ir;
        WB_EN = we; N_REG_IN = wr; REG_IN = wd;
        for (int n = 0; n < 8; n++) begin
            bit inc, dec;
            inc = ie && (ir == 3'(n));
            dec = we && (wr == 3'(n));
            if (inc && !dec) begin
                if (mcnt[n] == 3) movf = 1'b1;
                else mcnt[n]++;
            end
            if (dec && !inc) begin
                if (mcnt[n] == 0) munf = 1'b1;
                else mcnt[n]--;
            end
        end
        if (we) mreg[wr] = wd;
        exp_q.push_back(snapshot());
        @(posedge CLK_WB);
        #2;
        ISSUE_EN = 1'b0;
        WB_EN = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK_WB);
        #2 N_RESET = 1'b0;
        model_reset();
        #1 check_all(tag, snapshot());
        @(negedge CLK_WB);
        N_RESET = 1'b1;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge CLK_WB);
        #1 check_all("reset_init", snapshot());
        @(negedge CLK_WB);
        N_RESET = 1'b1;

        // write/readback with no prior issue
        step(1'b0, 3'd0, 1'b1, 3'd5, 16'hBEEF);
        chk("wr REG_5", {16'h0, REG_5}, 32'h0000BEEF);
        chk("wr REG_4", {16'h0, REG_4}, 32'h0);
        chk("wr UNF", {31'h0, UNF}, 32'h1);
        step(1'b0, 3'd0, 1'b1, 3'd0, 16'h5A5A);
        chk("wr REG_0", {16'h0, REG_0}, 32'h00005A5A);

        // asynchronous reset mid-run
        do_reset("reset_mid");
        chk("rst REG_5", {16'h0, REG_5}, 32'h0);

        // scoreboard r3: issue, issue, wb, wb
        step(1'b1, 3'd3, 1'b0, 3'd0, 16'h0);
        chk("sb P3 e1", {31'h0, PENDING[3]}, 32'h1);
        step(1'b1, 3'd3, 1'b0, 3'd0, 16'h0);
        chk("sb P3 e2", {31'h0, PENDING[3]}, 32'h1);
        step(1'b0, 3'd0, 1'b1, 3'd3, 16'h1111);
        chk("sb P3 e3", {31'h0, PENDING[3]}, 32'h1);
        step(1'b0, 3'd0, 1'b1, 3'd3, 16'h2222);
        chk("sb P3 e4", {31'h0, PENDING[3]}, 32'h0);
        chk("sb REG_3", {16'h0, REG_3}, 32'h00002222);
        chk("sb OVF", {31'h0, OVF}, 32'h0);
        chk("sb UNF", {31'h0, UNF}, 32'h0);

        // saturation on r7
        do_reset("reset_sat");
        repeat (3) step(1'b1, 3'd7, 1'b0, 3'd0, 16'h0);
        chk("sat OVF pre", {31'h0, OVF}, 32'h0);
        step(1'b1, 3'd7, 1'b0, 3'd0, 16'h0);
        chk("sat OVF", {31'h0, OVF}, 32'h1);
        chk("sat P7", {31'h0, PENDING[7]}, 32'h1);
        step(1'b0, 3'd0, 1'b1, 3'd7, 16'h0001);
        step(1'b0, 3'd0, 1'b1, 3'd7, 16'h0002);
        chk("sat P7 mid", {31'h0, PENDING[7]}, 32'h1);
        step(1'b0, 3'd0, 1'b1, 3'd7, 16'h0003);
        chk("sat P7 clr", {31'h0, PENDING[7]}, 32'h0);
        chk("sat UNF pre", {31'h0, UNF}, 32'h0);
        step(1'b0, 3'd0, 1'b1, 3'd7, 16'h0004);
        chk("sat UNF", {31'h0, UNF}, 32'h1);
        chk("sat REG_7", {16'h0, REG_7}, 32'h00000004);
        chk("sat OVF sticky", {31'h0, OVF}, 32'h1);

        // simultaneous issue/write-back
        do_reset("reset_sim");
        step(1'b1, 3'd2, 1'b0, 3'd0, 16'h0);
        step(1'b1, 3'd2, 1'b1, 3'd2, 16'h1234);
        chk("sim REG_2", {16'h0, REG_2}, 32'h00001234);
        chk("sim P2", {31'h0, PENDING[2]}, 32'h1);
        chk("sim UNF0", {31'h0, UNF}, 32'h0);
        step(1'b1, 3'd1, 1'b1, 3'd6, 16'hABCD);
        chk("sim P1", {31'h0, PENDING[1]}, 32'h1);
        chk("sim P6", {31'h0, PENDING[6]}, 32'h0);
        chk("sim UNF", {31'h0, UNF}, 32'h1);
        chk("sim REG_6", {16'h0, REG_6}, 32'h0000ABCD);
        // inc & dec at count 0 leaves it at 0 with no flag
        do_reset("reset_sim0");
        step(1'b1, 3'd4, 1'b1, 3'd4, 16'h7777);
        chk("sim0 P4", {31'h0, PENDING[4]}, 32'h0);
        chk("sim0 UNF", {31'h0, UNF}, 32'h0);

        // random traffic against the model
        do_reset("reset_rand");
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 16'($urandom));
            if (i == 1500) do_reset("reset_rand_mid");
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK_WB);
        #3;
        chk("queue drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
